// File: rtl/mdr_access_ctrl.sv
// mdr_access_ctrl: MDR capture/drive sequencer and memory handshake for one access at a time.
// Define MDR_ACCESS_TIMEOUT_EN to abort a memory wait after TIMEOUT cycles with err.
module mdr_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic              mem_ready_i,
  output logic              mdr_read_en_o,
  output logic              mdr_write_en_o,
  output logic              mdr_out_en_o
);
  // FINISH is split into three flops so done/err/mdr_out_en all come straight from state bits
  localparam logic [7:0] S_IDLE    = 8'h01;
  localparam logic [7:0] S_WLATCH  = 8'h02;
  localparam logic [7:0] S_WMEM    = 8'h04;
  localparam logic [7:0] S_RMEM    = 8'h08;
  localparam logic [7:0] S_RLATCH  = 8'h10;
  localparam logic [7:0] S_FIN     = 8'h20;
  localparam logic [7:0] S_FIN_RD  = 8'h40;
  localparam logic [7:0] S_FIN_ERR = 8'h80;

  logic [7:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic idle, wlatch, wmem, rmem, rlatch, fin, fin_rd, fin_err, accept, to;

  assign {fin_err, fin_rd, fin, rlatch, rmem, wmem, wlatch, idle} = state_q;
  assign accept = idle & req_i;
  assign addr_d = accept ? req_addr_i : addr_q;

  assign state_d = ((idle & ~req_i) | fin | fin_rd | fin_err ? S_IDLE : 8'h00)
                 | (accept & req_write_i ? S_WLATCH : 8'h00)
                 | (wlatch | (wmem & ~mem_ready_i & ~to) ? S_WMEM : 8'h00)
                 | ((accept & ~req_write_i) | (rmem & ~mem_ready_i & ~to) ? S_RMEM : 8'h00)
                 | (rmem & mem_ready_i ? S_RLATCH : 8'h00)
                 | (wmem & mem_ready_i ? S_FIN : 8'h00)
                 | (rlatch ? S_FIN_RD : 8'h00)
                 | (to ? S_FIN_ERR : 8'h00);

`ifdef MDR_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (rmem | wmem) & ~mem_ready_i ? cnt_q + CW'(1) : '0;
  assign to    = (rmem | wmem) & ~mem_ready_i & (cnt_q == CW'(TIMEOUT - 1));
  assign err_o = fin_err;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
`else
  assign to    = TIMEOUT < 0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end

  assign busy_o         = ~idle;
  assign done_o         = fin | fin_rd | fin_err;
  assign mem_addr_o     = addr_q;
  assign mem_rd_o       = rmem | rlatch;
  assign mem_wr_o       = wmem;
  assign mdr_read_en_o  = rlatch;
  assign mdr_write_en_o = wlatch;
  assign mdr_out_en_o   = fin_rd;
endmodule

// File: tb/tb_mdr_access_ctrl.sv
// tb_mdr_access_ctrl: directed checks of the MDR access sequencer with a behavioural MDR and bus.
module tb_mdr_access_ctrl;
  logic        clk = 0, reset = 1, req = 0, req_write = 0, mem_ready = 0;
  logic [15:0] req_addr = '0, bus_drive = '0, mem_data = '0, mdr = '0;
  logic        busy, done, err, mem_rd, mem_wr, mdr_read_en, mdr_write_en, mdr_out_en;
  logic [15:0] mem_addr;
  logic [15:0] bus;
  logic [7:0]  outs;
  logic        saw_rd_en = 0, saw_out_en = 0;
  int          checks = 0, errors = 0;

  mdr_access_ctrl dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_write_i(req_write), .req_addr_i(req_addr),
    .busy_o(busy), .done_o(done), .err_o(err), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd),
    .mem_wr_o(mem_wr), .mem_ready_i(mem_ready), .mdr_read_en_o(mdr_read_en),
    .mdr_write_en_o(mdr_write_en), .mdr_out_en_o(mdr_out_en)
  );

  always #5 clk = ~clk;

  assign bus  = mdr_out_en ? mdr : bus_drive;
  assign outs = {busy, done, err, mem_rd, mem_wr, mdr_read_en, mdr_write_en, mdr_out_en};
  always @(posedge mdr_write_en) mdr = bus_drive;
  always @(posedge mdr_read_en) begin mdr = mem_data; saw_rd_en = 1; end
  always @(posedge mdr_out_en) saw_out_en = 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // outs bit order: busy done err rd wr rd_en wr_en out_en
  initial begin
    cyc();
    chk("reset outs", {8'h0, outs}, 16'h0000);
    chk("reset addr", mem_addr, 16'h0000);
    reset = 0;
    cyc();
    chk("idle outs", {8'h0, outs}, 16'h0000);
    // write 0x1234 <- 0xBEEF, memReady already high
    mem_ready = 1; req = 1; req_write = 1; req_addr = 16'h1234; bus_drive = 16'hBEEF;
    cyc();
    chk("wr wlatch", {8'h0, outs}, 16'h0082);
    req = 0; req_addr = 16'h0000;
    cyc();
    chk("wr wmem", {8'h0, outs}, 16'h0088);
    chk("wr addr", mem_addr, 16'h1234);
    bus_drive = 16'h0000;
    req = 1; req_write = 0; req_addr = 16'h9999;
    cyc();
    chk("wr finish", {8'h0, outs}, 16'h00C0);
    chk("wr mdr", mdr, 16'hBEEF);
    req = 0;
    cyc();
    chk("wr idle after", {8'h0, outs}, 16'h0000);
    chk("addr held", mem_addr, 16'h1234);
    // read 0x00A5 -> 0x5A5A with three wait cycles
    mem_ready = 0; req = 1; req_write = 0; req_addr = 16'h00A5; mem_data = 16'h5A5A;
    cyc();
    req = 0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("rd wait %0d", i), {8'h0, outs}, 16'h0090);
      cyc();
    end
    chk("rd rmem c4", {8'h0, outs}, 16'h0090);
    chk("rd addr", mem_addr, 16'h00A5);
    mem_ready = 1;
    cyc();
    chk("rd rlatch", {8'h0, outs}, 16'h0094);
    mem_ready = 0;
    cyc();
    chk("rd finish", {8'h0, outs}, 16'h00C1);
    chk("rd bus", bus, 16'h5A5A);
    req = 1; req_write = 1; req_addr = 16'h0F0F; bus_drive = 16'h1111;
    cyc();
    chk("req in finish ignored", {8'h0, outs}, 16'h0000);
    chk("addr kept", mem_addr, 16'h00A5);
    cyc();
    chk("held req accepted", {8'h0, outs}, 16'h0082);
    chk("new addr", mem_addr, 16'h0F0F);
    req = 0;
    cyc();
    chk("wmem waits", {8'h0, outs}, 16'h0088);
    cyc();
    chk("wmem still waits", {8'h0, outs}, 16'h0088);
    chk("mdr second write", mdr, 16'h1111);
    // asynchronous reset in WMEM
    #1 reset = 1;
    #1 chk("async rst outs", {8'h0, outs}, 16'h0000);
    chk("async rst addr", mem_addr, 16'h0000);
    cyc();
    reset = 0;
`ifdef MDR_ACCESS_TIMEOUT_EN
    // read timeout with memReady stuck low
    saw_rd_en = 0; saw_out_en = 0;
    req = 1; req_write = 0; req_addr = 16'h0042;
    cyc();
    req = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 1 || i == 16) chk($sformatf("to rmem %0d", i), {8'h0, outs}, 16'h0090);
      cyc();
    end
    chk("to finish", {8'h0, outs}, 16'h00E0);
    cyc();
    chk("to idle", {8'h0, outs}, 16'h0000);
    chk("to no strobes", {14'h0, saw_rd_en, saw_out_en}, 16'h0000);
    // memReady arrives in the limit cycle
    req = 1;
    cyc();
    req = 0;
    for (int i = 1; i < 16; i++) cyc();
    chk("lim rmem", {8'h0, outs}, 16'h0090);
    mem_ready = 1;
    cyc();
    mem_ready = 0;
    chk("lim rlatch", {8'h0, outs}, 16'h0094);
    cyc();
    chk("lim finish", {8'h0, outs}, 16'h00C1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdr_access_ctrl.md
# mdr_access_ctrl

Sequencer for the memory data register (MDR) and the external memory handshake. It accepts one read or write request at a time from the control unit and latches the address. It drives memory read/write strobes until the memory acknowledges. It generates the MDR capture strobes (read-side and write-side) and the MDR bus-drive enable, in the correct order. It sits between the control unit, the MDR and the memory port.

## Interface
Parameters:
- ADDR_W, 16: width of request and memory address.
- TIMEOUT, 16: maximum wait cycles for memReady per access (≥2). Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request from control unit; sampled only in IDLE.
- reqWrite  in  1  1 = write access, 0 = read access; sampled with req.
- reqAddr  in  ADDR_W  access address; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in FINISH.
- err  out  1  one-cycle pulse with done on timeout abort; constant 0 without the macro.
- memAddr  out  ADDR_W  address latched at request acceptance.
- memRd  out  1  memory read strobe.
- memWr  out  1  memory write strobe.
- memReady  in  1  memory acknowledge; sampled in RMEM/WMEM only.
- mdrReadEn  out  1  MDR memory-side capture strobe; its rising edge loads memory read data.
- mdrWriteEn  out  1  MDR bus-side capture strobe; its rising edge loads the shared bus.
- mdrOutEn  out  1  MDR drives the shared bus while high.

## Operation
- States: IDLE, WLATCH, WMEM, RMEM, RLATCH, FINISH. The state register is one-hot.
- All outputs decode directly from state flops or registers. mdrReadEn, mdrWriteEn and mdrOutEn each equal exactly one state flop, with no gating logic. This keeps the strobes glitch-free, which matters because the MDR uses them as edge clocks.
- IDLE: on req=1, latch reqAddr into memAddr.
  - reqWrite=1: go to WLATCH.
  - reqWrite=0: go to RMEM.
- WLATCH (one cycle): mdrWriteEn=1. The requester must hold write data on the bus during the acceptance cycle and during WLATCH. Next state is WMEM.
- WMEM: memWr=1.
  - memReady=1: go to FINISH.
  - Otherwise: stay.
- RMEM: memRd=1.
  - memReady=1: go to RLATCH.
  - Otherwise: stay.
- RLATCH (one cycle): memRd=1 and mdrReadEn=1. The memory holds read data valid while memRd is high. Next state is FINISH.
- FINISH (one cycle): done=1. After a successful read, mdrOutEn=1 so the destination register can load the bus. Next state is IDLE.
- req asserted in any state other than IDLE is ignored and is not queued. A request must stay high until busy rises.
- memAddr holds its value from acceptance until the next acceptance.
- Reset values: state IDLE; memAddr 0; all strobes, busy, done and err 0.
- Asserting reset mid-operation forces IDLE and zeroes outputs immediately. There is no completion pulse. A half-written MDR keeps whatever it captured.

## Timing
- Cycle 0 is the edge where IDLE samples req=1.
- Write with memReady already high: WLATCH in cycle 1, WMEM in cycle 2, done in cycle 3. Minimum latency is 3 cycles; each extra memReady wait adds 1.
- Read with memReady already high: RMEM in cycle 1, RLATCH in cycle 2, done and mdrOutEn in cycle 3. Minimum latency is 3 cycles.
- Back-to-back requests: the earliest next acceptance is the cycle after FINISH, so throughput is one access per 4 cycles.
- memRd and memWr are never high in the same cycle.
- mdrReadEn and mdrWriteEn are never high in the same cycle.
- mdrOutEn is never high while memRd is high.

## Configuration
- MDR_ACCESS_TIMEOUT_EN defined:
  - A wait counter, cleared on entry to RMEM/WMEM, increments each cycle memReady=0.
  - When the counter equals TIMEOUT-1 with memReady=0, go to FINISH with err=1 and done=1.
  - A read abort skips RLATCH and does not assert mdrOutEn.
  - memReady=1 in the same cycle as the limit wins: normal completion, err=0.
- MDR_ACCESS_TIMEOUT_EN undefined: no counter; waits indefinitely; err tied to 0.

## Test plan
- Reset → state IDLE; memAddr=0; all outputs 0. Assert reset during WMEM → outputs drop to 0 asynchronously.
- Write, addr 0x1234, bus 0xBEEF, memReady held 1 → mdrWriteEn high in cycle 1; memWr high in cycle 2 with memAddr=0x1234; done in cycle 3; MDR output = 0xBEEF.
- Read, addr 0x00A5, memory data 0x5A5A, memReady after 3 waits → memRd high in cycles 1-5; mdrReadEn in cycle 5; done and mdrOutEn in cycle 6; bus = 0x5A5A.
- Second req pulsed in WMEM and in FINISH → ignored. A req held through FINISH is accepted in the following IDLE cycle with the new address.
- With MDR_ACCESS_TIMEOUT_EN and TIMEOUT=16, read with memReady stuck 0 → FINISH at cycle 17 with err=1, done=1, mdrReadEn and mdrOutEn never high.
- Same case with memReady rising in the limit cycle → normal read completion with err=0.
